// File: rtl/fnd_pkg.sv
// Shared code words, state encoding and helpers for the FND display arbiter.
package fnd_pkg;

  localparam int unsigned FND_W  = 32;
  localparam int unsigned CODE_W = 3;

  localparam logic [FND_W-1:0] FND_CODE_ERR      = 32'h00EE_0000;
  localparam logic [FND_W-1:0] FND_CODE_PLUS     = 32'h0010_0000;
  localparam logic [FND_W-1:0] FND_CODE_MINUS    = 32'h0020_0000;
  localparam logic [FND_W-1:0] FND_CODE_MULTIPLE = 32'h0030_0000;
  localparam logic [FND_W-1:0] FND_CODE_DIVID    = 32'h0040_0000;
  localparam logic [FND_W-1:0] FND_CODE_MODULO   = 32'h0050_0000;
  localparam logic [FND_W-1:0] FND_CODE_HAPPY    = 32'h00A0_0000;

  localparam int FND_MAX = 999_999;
  localparam int FND_MIN = -99_999;

  typedef enum logic [1:0] {
    ST_VAL = 2'd0,
    ST_MSG = 2'd1,
    ST_ERR = 2'd2
  } fnd_state_e;

  function automatic logic msg_code_valid(input logic [CODE_W-1:0] code);
    return (code != 3'd0) && (code != 3'd7);
  endfunction

  function automatic logic [FND_W-1:0] msg_code_word(input logic [CODE_W-1:0] code);
    logic [FND_W-1:0] word;
    word = '0;
    case (code)
      3'd1:    word = FND_CODE_PLUS;
      3'd2:    word = FND_CODE_MINUS;
      3'd3:    word = FND_CODE_MULTIPLE;
      3'd4:    word = FND_CODE_DIVID;
      3'd5:    word = FND_CODE_MODULO;
      3'd6:    word = FND_CODE_HAPPY;
      default: word = '0;
    endcase
    return word;
  endfunction

  // Six digits with the sign taking the top digit.
  function automatic logic fnd_in_range(input logic [FND_W-1:0] v);
    return ($signed(v) <= FND_MAX) && ($signed(v) >= FND_MIN);
  endfunction

endpackage

// File: rtl/fnd_hold_timer.sv
// Display hold timer: reloads to HOLD_CYCLES-1, counts down, flags zero.
module fnd_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired_c
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Stops at zero; only a reload moves it away from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/fnd_display_arbiter.sv
// Arbitrates the FND word between the latched value, timed messages and error notices.
module fnd_display_arbiter
  import fnd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              val_valid,
  input  logic [FND_W-1:0]  val_data,
  input  logic              msg_req,
  input  logic [CODE_W-1:0] msg_code,
  output logic              msg_ack,
  input  logic              err_req,
  output logic              err_ack,
  output logic [FND_W-1:0]  fnd_serial,
  output logic              busy,
  output logic              ovf
);

  fnd_state_e       state_q, state_d;
  logic             timer_load_c, timer_expired_c, load_msg_c;
  logic             msg_ack_d, err_ack_d, busy_d, ovf_d;
  logic [FND_W-1:0] val_reg, val_d, fnd_d;

  fnd_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load_c),
    .expired_c (timer_expired_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_VAL;
    else        state_q <= state_d;
  end

  // Priority err > msg > val; msg is left pending (unacked) while an error is shown.
  always_comb begin
    state_d      = state_q;
    timer_load_c = 1'b0;
    load_msg_c   = 1'b0;
    msg_ack_d    = 1'b0;
    err_ack_d    = 1'b0;
    case (state_q)
      ST_VAL: begin
        if (err_req) begin
          state_d      = ST_ERR;
          timer_load_c = 1'b1;
          err_ack_d    = 1'b1;
        end else if (msg_req) begin
          msg_ack_d = 1'b1;
          if (msg_code_valid(msg_code)) begin
            state_d      = ST_MSG;
            timer_load_c = 1'b1;
            load_msg_c   = 1'b1;
          end
        end
      end
      ST_MSG: begin
        if (err_req) begin
          state_d      = ST_ERR;
          timer_load_c = 1'b1;
          err_ack_d    = 1'b1;
        end else if (msg_req && msg_code_valid(msg_code)) begin
          msg_ack_d    = 1'b1;
          timer_load_c = 1'b1;
          load_msg_c   = 1'b1;
        end else begin
          msg_ack_d = msg_req;
          if (timer_expired_c) state_d = ST_VAL;
        end
      end
      ST_ERR: begin
        if (err_req) begin
          timer_load_c = 1'b1;
          err_ack_d    = 1'b1;
        end else if (timer_expired_c) begin
          state_d = ST_VAL;
          if (msg_req) begin
            msg_ack_d = 1'b1;
            if (msg_code_valid(msg_code)) begin
              state_d      = ST_MSG;
              timer_load_c = 1'b1;
              load_msg_c   = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_VAL;
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    val_d  = val_valid ? val_data : val_reg;
    ovf_d  = !fnd_in_range(val_d);
    busy_d = (state_d != ST_VAL);
    fnd_d  = fnd_serial;
    case (state_d)
      ST_VAL:  fnd_d = ovf_d ? FND_CODE_ERR : val_d;
      ST_MSG:  fnd_d = load_msg_c ? msg_code_word(msg_code) : fnd_serial;
      ST_ERR:  fnd_d = FND_CODE_ERR;
      default: fnd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_reg    <= '0;
      fnd_serial <= '0;
      msg_ack    <= 1'b0;
      err_ack    <= 1'b0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      val_reg    <= val_d;
      fnd_serial <= fnd_d;
      msg_ack    <= msg_ack_d;
      err_ack    <= err_ack_d;
      busy       <= busy_d;
      ovf        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Scoreboard bench for fnd_display_arbiter with a short hold time.
module tb_fnd_display_arbiter;

  typedef struct packed {
    logic [31:0] fnd;
    logic        busy;
    logic        ovf;
    logic        mack;
    logic        eack;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        val_valid = 1'b0;
  logic [31:0] val_data = '0;
  logic        msg_req = 1'b0;
  logic [2:0]  msg_code = '0;
  logic        msg_ack;
  logic        err_req = 1'b0;
  logic        err_ack;
  logic [31:0] fnd_serial;
  logic        busy;
  logic        ovf;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  fnd_display_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .val_valid  (val_valid),
    .val_data   (val_data),
    .msg_req    (msg_req),
    .msg_code   (msg_code),
    .msg_ack    (msg_ack),
    .err_req    (err_req),
    .err_ack    (err_ack),
    .fnd_serial (fnd_serial),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [31:0] f, logic b, logic o, logic m, logic e);
    exp_t x;
    x.fnd = f; x.busy = b; x.ovf = o; x.mack = m; x.eack = e;
    return x;
  endfunction

  function automatic exp_t obs();
    return mk(fnd_serial, busy, ovf, msg_ack, err_ack);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back(mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL reset: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_value();
    exp_t e;
    val_data = 32'd1234; val_valid = 1'b1;
    sb.push_back(mk(32'd1234, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    val_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL value_1234: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_msg_timing();
    exp_t e;
    msg_code = 3'd3; msg_req = 1'b1;
    sb.push_back(mk(32'h0030_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    repeat (3) sb.push_back(mk(32'h0030_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'd1234, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'd1234, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; sb.size() != 0; i++) begin
      step();
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL msg_timing[%0d]: got %h want %h", i, obs(), e);
      end
      if (msg_ack) msg_req = 1'b0;
    end
  endtask

  task automatic test_preempt();
    exp_t e;
    // Message preempted by an error after two cycles.
    msg_code = 3'd1; msg_req = 1'b1;
    sb.push_back(mk(32'h0010_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(32'h0010_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'h00EE_0000, 1'b1, 1'b0, 1'b0, 1'b1));
    repeat (3) sb.push_back(mk(32'h00EE_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'd1234, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; sb.size() != 0; i++) begin
      step();
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL preempt[%0d]: got %h want %h", i, obs(), e);
      end
      if (msg_ack) msg_req = 1'b0;
      if (err_ack) err_req = 1'b0;
      if (i == 1) err_req = 1'b1;
    end
    // Message held during an error is acked at the error's expiry.
    err_req = 1'b1;
    sb.push_back(mk(32'h00EE_0000, 1'b1, 1'b0, 1'b0, 1'b1));
    repeat (3) sb.push_back(mk(32'h00EE_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'h00A0_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    repeat (3) sb.push_back(mk(32'h00A0_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'd1234, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; sb.size() != 0; i++) begin
      step();
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL pending_msg[%0d]: got %h want %h", i, obs(), e);
      end
      if (msg_ack) msg_req = 1'b0;
      if (err_ack) err_req = 1'b0;
      if (i == 0) begin
        msg_code = 3'd6; msg_req = 1'b1;
      end
    end
  endtask

  task automatic test_range();
    exp_t        e;
    logic [31:0] vals [5];
    vals[0] = 32'd1_000_000;
    vals[1] = -32'sd100_000;
    vals[2] = -32'sd99_999;
    vals[3] = 32'd999_999;
    vals[4] = 32'd1234;
    sb.push_back(mk(32'h00EE_0000, 1'b0, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(32'h00EE_0000, 1'b0, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(32'hFFFE_7961, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'h000F_423F, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'd1234, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; sb.size() != 0; i++) begin
      val_data = vals[i]; val_valid = 1'b1;
      step();
      val_valid = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL range[%0d]: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_deferred_invalid();
    exp_t e;
    msg_code = 3'd2; msg_req = 1'b1;
    sb.push_back(mk(32'h0020_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    repeat (3) sb.push_back(mk(32'h0020_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'd42, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; sb.size() != 0; i++) begin
      step();
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL deferred_val[%0d]: got %h want %h", i, obs(), e);
      end
      if (msg_ack) msg_req = 1'b0;
      val_valid = (i == 1);
      val_data  = 32'd42;
    end
    val_valid = 1'b0;
    msg_code = 3'd7; msg_req = 1'b1;
    sb.push_back(mk(32'd42, 1'b0, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(32'd42, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; sb.size() != 0; i++) begin
      step();
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL invalid_code[%0d]: got %h want %h", i, obs(), e);
      end
      if (msg_ack) msg_req = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    msg_code = 3'd5; msg_req = 1'b1; err_req = 1'b1;
    sb.push_back(mk(32'h00EE_0000, 1'b1, 1'b0, 1'b0, 1'b1));
    repeat (3) sb.push_back(mk(32'h00EE_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'h0050_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    repeat (3) sb.push_back(mk(32'h0050_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'd42, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; sb.size() != 0; i++) begin
      step();
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL simultaneous[%0d]: got %h want %h", i, obs(), e);
      end
      if (msg_ack) msg_req = 1'b0;
      if (err_ack) err_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_err();
    exp_t e;
    err_req = 1'b1;
    sb.push_back(mk(32'h00EE_0000, 1'b1, 1'b0, 1'b0, 1'b1));
    sb.push_back(mk(32'h00EE_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; sb.size() != 0; i++) begin
      step();
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL err_before_reset[%0d]: got %h want %h", i, obs(), e);
      end
      if (err_ack) err_req = 1'b0;
    end
    // Asynchronous: outputs clear without waiting for an edge.
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", obs(), e);
    end
    step();
    rst_n = 1'b1;
    sb.push_back(mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; sb.size() != 0; i++) begin
      step();
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL after_reset[%0d]: got %h want %h", i, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_value();
    test_msg_timing();
    test_preempt();
    test_range();
    test_deferred_invalid();
    test_simultaneous();
    test_reset_mid_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
